// File: rtl/z_pulse_monitor_pkg.sv
// Shared types and default parameters for the z pulse monitor: level-state
// and report-slot encodings used by the top and its filter sub-module.
package z_mon_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_CYCLES = 4;
    localparam int DEF_CNT_W       = 8;

    typedef enum logic {
        LVL_LOW  = 1'b0,
        LVL_HIGH = 1'b1
    } lvl_state_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : z_mon_pkg

// File: rtl/z_pulse_monitor_if.sv
// Pulse-width report channel: single-entry valid/ready slot from the monitor
// (master) to the downstream logger or register block (slave).
interface z_pulse_monitor_if
    import z_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_data;

    modport master (
        output rpt_valid,
        output rpt_data,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_data,
        output rpt_ready
    );

endinterface : z_pulse_monitor_if

// File: rtl/z_pulse_monitor_sync_filter.sv
// Brings the asynchronous z net into the clk domain and only adopts a new
// level after it has persisted for FILT_CYCLES consecutive edges.
module z_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic z_in,
    output logic z_filt,
    output logic z_chg
);

    localparam int              FC_W    = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FC_W-1:0]        filt_cnt_q;
    logic                   sync_out;
    logic                   differ;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign differ   = sync_out ^ z_filt;

    // z_chg is a look-ahead: z_filt flips on the coming edge. The top uses it
    // so its FSMs, counters and report slot move on the same edge as z_filt.
    assign z_chg = differ && (filt_cnt_q == FC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q     <= '0;
            filt_cnt_q <= '0;
            z_filt     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], z_in};
            if (!differ || z_chg) begin
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
            if (z_chg) begin
                z_filt <= ~z_filt;
            end
        end
    end

endmodule : z_sync_filter

// File: rtl/z_pulse_monitor.sv
// Qualified z event counter and high-pulse width meter; each completed width
// is offered downstream through a single-entry valid/ready report slot.
module z_pulse_monitor
    import z_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               z_in,
    input  logic               clr,
    output logic               z_filt,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic [CNT_W-1:0]   evt_cnt,
    output logic               cnt_sat,
    output logic               rpt_ovf,
    z_pulse_monitor_if.master  rpt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             z_chg;
    logic             rise_evt;
    logic             fall_evt;
    lvl_state_e       lvl_q;
    lvl_state_e       lvl_d;
    slot_state_e      slot_q;
    slot_state_e      slot_d;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;
    logic [CNT_W-1:0] evt_cnt_d;
    logic [CNT_W-1:0] rpt_data_d;
    logic             cnt_sat_d;
    logic             rpt_ovf_d;

    z_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_sync_filter (
        .clk    (clk),
        .rstn   (rstn),
        .z_in   (z_in),
        .z_filt (z_filt),
        .z_chg  (z_chg)
    );

    // Level FSM tracks z_filt edge-for-edge; transitions are the event strobes.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        lvl_d    = lvl_q;
        rise_evt = 1'b0;
        fall_evt = 1'b0;
        case (lvl_q)
            LVL_LOW: begin
                if (z_chg) begin
                    lvl_d    = LVL_HIGH;
                    rise_evt = 1'b1;
                end
            end
            LVL_HIGH: begin
                if (z_chg) begin
                    lvl_d    = LVL_LOW;
                    fall_evt = 1'b1;
                end
            end
            default: lvl_d = LVL_LOW;
        endcase
    end

    // Width starts at 1 on the rise edge so the value held at the fall edge is
    // exactly the number of cycles z_filt spent high.
    always_comb begin
        width_d = width_q;
        if (rise_evt) begin
            width_d = CNT_W'(1);
        end else if ((lvl_q == LVL_HIGH) && !fall_evt && (width_q != CNT_MAX)) begin
            width_d = width_q + 1'b1;
        end
    end

    always_comb begin
        evt_cnt_d = evt_cnt;
        cnt_sat_d = cnt_sat;
        if (clr) begin
            evt_cnt_d = '0;
            cnt_sat_d = 1'b0;
        end else if (rise_evt && (evt_cnt != CNT_MAX)) begin
            evt_cnt_d = evt_cnt + 1'b1;
            if (evt_cnt_d == CNT_MAX) begin
                cnt_sat_d = 1'b1;
            end
        end
    end

    // Report slot: a pulse ending during an accepted handshake reloads the slot;
    // one ending while the slot is stalled is dropped and flagged.
    always_comb begin
        slot_d     = slot_q;
        rpt_data_d = rpt.rpt_data;
        rpt_ovf_d  = rpt_ovf;
        if (clr) begin
            slot_d    = SLOT_EMPTY;
            rpt_ovf_d = 1'b0;
        end else begin
            case (slot_q)
                SLOT_EMPTY: begin
                    if (fall_evt) begin
                        slot_d     = SLOT_FULL;
                        rpt_data_d = width_q;
                    end
                end
                SLOT_FULL: begin
                    if (rpt.rpt_ready) begin
                        if (fall_evt) begin
                            rpt_data_d = width_q;
                        end else begin
                            slot_d = SLOT_EMPTY;
                        end
                    end else if (fall_evt) begin
                        rpt_ovf_d = 1'b1;
                    end
                end
                default: slot_d = SLOT_EMPTY;
            endcase
        end
    end

    assign rpt.rpt_valid = (slot_q == SLOT_FULL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl_q        <= LVL_LOW;
            slot_q       <= SLOT_EMPTY;
            width_q      <= '0;
            evt_cnt      <= '0;
            cnt_sat      <= 1'b0;
            rpt_ovf      <= 1'b0;
            rpt.rpt_data <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
        end else begin
            lvl_q        <= lvl_d;
            slot_q       <= slot_d;
            width_q      <= width_d;
            evt_cnt      <= evt_cnt_d;
            cnt_sat      <= cnt_sat_d;
            rpt_ovf      <= rpt_ovf_d;
            rpt.rpt_data <= rpt_data_d;
            rise_pulse   <= rise_evt;
            fall_pulse   <= fall_evt;
        end
    end

endmodule : z_pulse_monitor

// File: tb/tb_z_pulse_monitor.sv
// Directed bench for z_pulse_monitor: default instance plus a CNT_W=4 instance
// for saturation; report widths are checked by scoreboard monitors.
module tb_z_pulse_monitor;

    logic       clk = 1'b0;
    logic       rstn;
    logic       z_in, clr;
    logic       z_filt, rise_pulse, fall_pulse, cnt_sat, rpt_ovf;
    logic [7:0] evt_cnt;

    logic       z4, clr4;
    logic       z_filt4, rise4, fall4, cnt_sat4, rpt_ovf4;
    logic [3:0] evt_cnt4;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_q4[$];
    int exp_w;

    z_pulse_monitor_if #(.CNT_W(8)) rpt_if ();
    z_pulse_monitor_if #(.CNT_W(4)) rpt_if4 ();

    z_pulse_monitor dut (
        .clk        (clk),
        .rstn       (rstn),
        .z_in       (z_in),
        .clr        (clr),
        .z_filt     (z_filt),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .evt_cnt    (evt_cnt),
        .cnt_sat    (cnt_sat),
        .rpt_ovf    (rpt_ovf),
        .rpt        (rpt_if)
    );

    z_pulse_monitor #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .z_in       (z4),
        .clr        (clr4),
        .z_filt     (z_filt4),
        .rise_pulse (rise4),
        .fall_pulse (fall4),
        .evt_cnt    (evt_cnt4),
        .cnt_sat    (cnt_sat4),
        .rpt_ovf    (rpt_ovf4),
        .rpt        (rpt_if4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit on4, input int hi, input int gap);
        if (on4) z4 = 1'b1; else z_in = 1'b1;
        tick(hi);
        if (on4) z4 = 1'b0; else z_in = 1'b0;
        tick(gap);
    endtask

    // Scoreboard monitors: each accepted report pops its expected width.
    always @(negedge clk) begin
        if (rstn && rpt_if.rpt_valid && rpt_if.rpt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rpt_unexpected: got %0d expected none", rpt_if.rpt_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("rpt_data", int'(rpt_if.rpt_data), exp_w);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && rpt_if4.rpt_valid && rpt_if4.rpt_ready) begin
            if (exp_q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rpt4_unexpected: got %0d expected none", rpt_if4.rpt_data);
            end else begin
                check("rpt4_data", int'(rpt_if4.rpt_data), exp_q4.pop_front());
            end
        end
    end

    initial begin
        rstn = 1'b1;
        z_in = 1'b0;
        clr  = 1'b0;
        z4   = 1'b0;
        clr4 = 1'b0;
        rpt_if.rpt_ready  = 1'b1;
        rpt_if4.rpt_ready = 1'b1;
        #2 rstn = 1'b0;

        // Reset with z_in toggling, then 20 idle cycles after release.
        for (int i = 0; i < 6; i++) begin
            z_in = ~z_in;
            tick(1);
            check("reset_outputs", int'({z_filt, rise_pulse, fall_pulse, cnt_sat,
                  rpt_if.rpt_valid, rpt_ovf, evt_cnt}), 0);
        end
        z_in = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_outputs", int'({z_filt, rise_pulse, fall_pulse, cnt_sat,
                  rpt_if.rpt_valid, rpt_ovf, evt_cnt}), 0);
        end

        // Clean 10-cycle pulse with rpt_ready high.
        exp_q.push_back(10);
        z_in = 1'b1;
        tick(5);
        check("rise_early", int'(rise_pulse), 0);
        tick(1);
        check("rise_at_6", int'(rise_pulse), 1);
        check("z_filt_high", int'(z_filt), 1);
        check("evt_cnt_1", int'(evt_cnt), 1);
        tick(1);
        check("rise_one_cycle", int'(rise_pulse), 0);
        tick(3);
        z_in = 1'b0;
        tick(5);
        check("fall_early", int'(fall_pulse), 0);
        tick(1);
        check("fall_at_6", int'(fall_pulse), 1);
        check("rpt_valid_at_fall", int'(rpt_if.rpt_valid), 1);
        check("rpt_data_10", int'(rpt_if.rpt_data), 10);
        tick(1);
        check("rpt_valid_drained", int'(rpt_if.rpt_valid), 0);
        check("fall_one_cycle", int'(fall_pulse), 0);
        tick(8);

        // Glitch filter: 3 cycles rejected, 4 cycles qualified.
        z_in = 1'b1;
        tick(3);
        z_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("glitch_z_filt", int'(z_filt), 0);
            tick(1);
        end
        check("glitch_evt_cnt", int'(evt_cnt), 1);
        exp_q.push_back(4);
        pulse(1'b0, 4, 12);
        check("min_pulse_evt_cnt", int'(evt_cnt), 2);

        // Backpressure: 5-cycle report held, 7-cycle report dropped.
        rpt_if.rpt_ready = 1'b0;
        exp_q.push_back(5);
        pulse(1'b0, 5, 12);
        check("bp_valid", int'(rpt_if.rpt_valid), 1);
        check("bp_data_5", int'(rpt_if.rpt_data), 5);
        check("bp_no_ovf", int'(rpt_ovf), 0);
        pulse(1'b0, 7, 12);
        check("bp_data_held", int'(rpt_if.rpt_data), 5);
        check("bp_ovf", int'(rpt_ovf), 1);
        check("bp_evt_cnt", int'(evt_cnt), 4);
        rpt_if.rpt_ready = 1'b1;
        tick(1);
        rpt_if.rpt_ready = 1'b0;
        check("bp_drained", int'(rpt_if.rpt_valid), 0);
        check("bp_ovf_sticky", int'(rpt_ovf), 1);

        // clr coincident with a rise while the slot is full.
        pulse(1'b0, 6, 12);
        check("pre_clr_evt_cnt", int'(evt_cnt), 5);
        check("pre_clr_valid", int'(rpt_if.rpt_valid), 1);
        check("pre_clr_data", int'(rpt_if.rpt_data), 6);
        z_in = 1'b1;
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_evt_cnt", int'(evt_cnt), 0);
        check("clr_valid", int'(rpt_if.rpt_valid), 0);
        check("clr_ovf", int'(rpt_ovf), 0);
        check("clr_z_filt_kept", int'(z_filt), 1);

        // Async reset mid-pulse, z_in held high: re-qualified and counted.
        tick(3);
        rstn = 1'b0;
        #1;
        check("rst_z_filt", int'(z_filt), 0);
        check("rst_evt_cnt", int'(evt_cnt), 0);
        tick(2);
        rstn = 1'b1;
        rpt_if.rpt_ready = 1'b1;
        exp_q.push_back(10);
        tick(5);
        check("requal_early", int'(z_filt), 0);
        tick(1);
        check("requal_z_filt", int'(z_filt), 1);
        check("requal_evt_cnt", int'(evt_cnt), 1);
        tick(4);
        z_in = 1'b0;
        tick(12);

        // Saturation on the CNT_W=4 instance.
        for (int i = 0; i < 17; i++) begin
            exp_q4.push_back(4);
            pulse(1'b1, 4, 8);
            check("sat_evt_cnt", int'(evt_cnt4), (i + 1 > 15) ? 15 : i + 1);
            check("sat_flag", int'(cnt_sat4), (i + 1 >= 15) ? 1 : 0);
        end
        exp_q4.push_back(15);
        pulse(1'b1, 20, 12);
        check("sat_evt_cnt_final", int'(evt_cnt4), 15);
        check("sat_flag_final", int'(cnt_sat4), 1);

        check("sb_drained", exp_q.size(), 0);
        check("sb4_drained", exp_q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_z_pulse_monitor

// File: doc/z_pulse_monitor.md
Name: z_pulse_monitor

Overview:
Downstream consumer of the 5-input combinational z function. It synchronises the raw z net into the clock domain and rejects glitches with a stability filter. It counts qualified rising events and measures the width of each high pulse. Each completed pulse width is handed on through a single-entry valid/ready report slot to the next stage (logger or CPU register block).

Parameters:
SYNC_STAGES, 2, depth of input synchroniser flops (>=2)
FILT_CYCLES, 4, consecutive cycles a new level must persist before z_filt adopts it (>=1)
CNT_W, 8, width of event counter and pulse-width measurement

Ports:
clk  input  1  single clock, rising-edge
rstn  input  1  asynchronous active-low reset
z_in  input  1  raw z from combinational stage, asynchronous to clk, may glitch
clr  input  1  synchronous clear of counters, flags and report slot
rpt_ready  input  1  downstream accepts report when high with rpt_valid
z_filt  output  1  synchronised, filtered level
rise_pulse  output  1  one-cycle strobe on z_filt 0->1
fall_pulse  output  1  one-cycle strobe on z_filt 1->0
evt_cnt  output  CNT_W  number of qualified rising events, saturating
cnt_sat  output  1  sticky: evt_cnt reached 2^CNT_W-1
rpt_valid  output  1  report slot full
rpt_data  output  CNT_W  width of completed high pulse in clk cycles, saturating
rpt_ovf  output  1  sticky: a pulse completed while the slot was full and not draining

Behaviour:
- Reset (rstn low, async): synchroniser flops, filter counter, width counter and all outputs go to 0 immediately. They hold at 0 until the first clk edge after rstn deasserts.
- Synchroniser: SYNC_STAGES flops, reset to 0; sync_out is the last stage.
- Filter: counter increments on each edge where sync_out != z_filt and clears to 0 on any edge where they are equal.
  - On the FILT_CYCLES-th consecutive differing edge, z_filt toggles and the counter clears.
  - Latency from z_in change to z_filt change is SYNC_STAGES+FILT_CYCLES edges (6 with defaults).
  - A z_in pulse shorter than FILT_CYCLES cycles is fully rejected.
- Level FSM: two states, LOW and HIGH, mirroring z_filt.
  - LOW->HIGH drives rise_pulse high for exactly the one cycle after the transition edge.
  - HIGH->LOW drives fall_pulse high for that one cycle.
- Event counter: increments by 1 on each LOW->HIGH transition and saturates at 2^CNT_W-1. cnt_sat sets on the edge evt_cnt reaches max.
- Width counter: cleared on LOW->HIGH, then increments every edge in HIGH, saturating.
  - On HIGH->LOW, the captured value equals the number of cycles z_filt was 1, saturated to 2^CNT_W-1.
- Report slot, states EMPTY and FULL:
  - EMPTY + pulse end: load rpt_data, rpt_valid=1 on the same edge z_filt falls.
  - FULL + rpt_ready=1: handshake completes. Slot goes EMPTY next edge unless a pulse ends on that same edge, in which case new data loads and rpt_valid stays 1.
  - FULL + rpt_ready=0 + pulse end: new width is dropped, rpt_data holds, rpt_ovf sets.
  - rpt_data is stable while rpt_valid=1 and rpt_ready=0.
- clr (synchronous): zeroes evt_cnt, cnt_sat, rpt_ovf and rpt_valid.
  - clr wins over a coincident rise (not counted) and over a coincident pulse end (report dropped, no ovf).
  - Filter, z_filt and width measurement are unaffected.
- rstn asserted mid-pulse: everything clears. If z_in is still 1 after release, it is re-qualified as a new rise after SYNC_STAGES+FILT_CYCLES edges and counted.
- All arithmetic unsigned; no wrap-around anywhere (saturate only).

Decomposition:
- Shared package z_mon_pkg: level-state encoding (LOW/HIGH), slot-state encoding (EMPTY/FULL), default parameter constants.
- One sub-module, z_sync_filter (parameters SYNC_STAGES, FILT_CYCLES; ports clk, rstn, z_in, z_filt). The top holds the FSMs, counters and report slot.

Test Plan:
- Reset: rstn=0 with z_in toggling -> all outputs 0. Release with z_in=0, run 20 cycles -> outputs remain 0.
- Clean pulse, defaults, rpt_ready=1: z_in=1 for 10 cycles.
  - rise_pulse 6 edges after z_in rise, evt_cnt=1.
  - fall_pulse 6 edges after z_in fall, with rpt_valid=1 and rpt_data=10 for one cycle.
- Glitch filter: z_in=1 for 3 cycles -> z_filt stays 0, evt_cnt=0. z_in=1 for 4 cycles -> one event, rpt_data=4.
- Backpressure: rpt_ready=0, pulses of 5 then 7 cycles.
  - rpt_data=5 held, rpt_ovf=1.
  - Raise rpt_ready for 1 cycle -> rpt_valid=0 next edge, rpt_ovf stays 1.
- Saturation, CNT_W=4: 17 qualified pulses -> evt_cnt=15, cnt_sat=1. One 20-cycle pulse -> rpt_data=15.
- clr coincident with a rise -> evt_cnt=0, rpt_valid=0, rpt_ovf=0. rstn pulsed mid-pulse with z_in held 1 -> re-counted after 6 edges, evt_cnt=1.
